// File: rtl/mul_pkg.sv
// Constants shared by the Wallace-tree multiplier and its carry-propagate stage.
package mul_pkg;

   localparam int unsigned MUL_W           = 64;
   localparam int unsigned MUL_CPA_SLICE_W = 16;
   localparam int unsigned MUL_CPA_NSTG    = MUL_W / MUL_CPA_SLICE_W;

   // Carry-save pair as handed from the tree to the final adder.
   typedef struct packed {
      logic [MUL_W-1:0] sum;
      logic [MUL_W-1:0] carry;
   } mul_cs_t;

endpackage

// File: rtl/cpa_slice.sv
// One slice of the final adder: a SLICE_W-bit ripple add with carry in and out.
module cpa_slice
   import mul_pkg::*;
#(
   parameter int unsigned SLICE_W = MUL_CPA_SLICE_W
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   assign {cout, s} = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);

endmodule

// File: rtl/mul_cpa_pipe.sv
// Staircase-pipelined carry-propagate adder turning the tree's carry-save pair into the product.
// Define MUL_CPA_COUT_EN to expose the top-slice carry on out_cout.
module mul_cpa_pipe
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH   = MUL_W,
   parameter int unsigned SLICE_W = MUL_CPA_SLICE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_prod
`ifdef MUL_CPA_COUT_EN
   ,
   output logic             out_cout
`endif
);

   localparam int unsigned NSTG = WIDTH / SLICE_W;

   logic                 adv;
   logic [NSTG-1:0]      st_v;
   logic [NSTG-1:0]      st_cin;
   logic [WIDTH-1:0]     st_sum [NSTG];
   logic [WIDTH-1:0]     st_car [NSTG];
   logic [SLICE_W-1:0]   add_s  [NSTG];
   logic [NSTG-1:0]      add_co;

   // Whole pipe moves in lockstep; it only stalls when a finished result is waiting.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage k resolves slice k of the pair it holds, using the carry left by stage k-1.
   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      cpa_slice #(
         .SLICE_W (SLICE_W)
      ) u_slice (
         .a    (st_sum[k][k*SLICE_W +: SLICE_W]),
         .b    (st_car[k][k*SLICE_W +: SLICE_W]),
         .cin  (st_cin[k]),
         .s    (add_s[k]),
         .cout (add_co[k])
      );
   end

`ifndef MUL_CPA_COUT_EN
   // Carry out of the top slice is dropped when the cout port is not built.
   logic unused_top_cout;
   assign unused_top_cout = add_co[NSTG-1];
`endif

   // st_sum keeps finished bits below the active slice and raw sum bits above it.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_v      <= '0;
         st_cin    <= '0;
         out_valid <= 1'b0;
         out_prod  <= '0;
`ifdef MUL_CPA_COUT_EN
         out_cout  <= 1'b0;
`endif
         for (int k = 0; k < NSTG; k++) begin
            st_sum[k] <= '0;
            st_car[k] <= '0;
         end
      end else if (adv) begin
         st_v      <= {st_v[NSTG-2:0], in_valid};
         st_cin    <= {add_co[NSTG-2:0], 1'b0};
         st_sum[0] <= in_sum;
         st_car[0] <= in_carry;
         for (int k = 1; k < NSTG; k++) begin
            st_sum[k]                             <= st_sum[k-1];
            st_sum[k][(k-1)*SLICE_W +: SLICE_W]   <= add_s[k-1];
            st_car[k]                             <= st_car[k-1];
         end
         out_valid                                  <= st_v[NSTG-1];
         out_prod                                   <= st_sum[NSTG-1];
         out_prod[(NSTG-1)*SLICE_W +: SLICE_W]      <= add_s[NSTG-1];
`ifdef MUL_CPA_COUT_EN
         out_cout                                   <= add_co[NSTG-1];
`endif
      end
   end

endmodule

// File: tb/tb_mul_cpa_pipe.sv
// Scoreboard bench for mul_cpa_pipe; tracks out_cout as well when MUL_CPA_COUT_EN is defined.
module tb_mul_cpa_pipe;
   import mul_pkg::*;

   localparam int unsigned W = MUL_W;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_sum;
   logic [W-1:0] in_carry;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_prod;
   logic         cout_obs;

   int           checks = 0;
   int           errors = 0;
   logic [W:0]   exp_q [$];

   always #5 clk = ~clk;

   mul_cpa_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod)
`ifdef MUL_CPA_COUT_EN
      ,
      .out_cout  (cout_obs)
`endif
   );

`ifndef MUL_CPA_COUT_EN
   assign cout_obs = 1'b0;
`endif

   // Reference: plain unsigned add; carry-out is only observable with the port built.
   function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
`ifdef MUL_CPA_COUT_EN
      return {1'b0, s} + {1'b0, c};
`else
      return {1'b0, s + c};
`endif
   endfunction

   // Drives one cycle at the falling edge and reports what the next rising edge will transfer.
   task automatic cycle(input logic iv, input logic [W-1:0] s, input logic [W-1:0] c,
                        input logic ordy, output logic acc, output logic rdy,
                        output logic ov, output logic [W:0] got);
      @(negedge clk);
      in_valid  = iv;
      in_sum    = s;
      in_carry  = c;
      out_ready = ordy;
      #1;
      rdy = in_ready;
      ov  = out_valid;
      got = {cout_obs, out_prod};
      acc = iv && in_ready;
      if (acc) exp_q.push_back(model(s, c));
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_prod !== '0) begin errors++; $display("FAIL reset_out_prod: got %h expected 0", out_prod); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (cout_obs !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b expected 0", cout_obs); end
   endtask

   // Single pairs: small add with exact latency, then a carry rippling through every slice.
   task automatic test_single();
      logic [W-1:0] ts [2] = '{64'h3, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [W-1:0] tc [2] = '{64'h5, 64'h1};
      logic [W-1:0] tp [2] = '{64'h8, 64'h0};
      logic         tk [2] = '{1'b0, 1'b1};
      logic         acc, rdy, ov;
      logic [W:0]   got, e;
      int           lat;
      for (int t = 0; t < 2; t++) begin
         cycle(1'b1, ts[t], tc[t], 1'b1, acc, rdy, ov, got);
         checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept[%0d]: got %b expected 1", t, acc); end
         lat = -1;
         for (int i = 1; i <= 12 && lat < 0; i++) begin
            cycle(1'b0, '0, '0, 1'b1, acc, rdy, ov, got);
            if (ov) begin
               lat = i - 1;
               checks++;
               if (exp_q.size() == 0) begin errors++; $display("FAIL single_data[%0d]: unexpected output %h", t, got); end
               else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", t, got, e); end
               end
               checks++; if (got[W-1:0] !== tp[t]) begin errors++; $display("FAIL single_prod[%0d]: got %h expected %h", t, got[W-1:0], tp[t]); end
`ifdef MUL_CPA_COUT_EN
               checks++; if (got[W] !== tk[t]) begin errors++; $display("FAIL single_cout[%0d]: got %b expected %b", t, got[W], tk[t]); end
`else
               checks++; if (got[W] !== 1'b0 && tk[t] !== 1'bx) begin errors++; $display("FAIL single_cout[%0d]: got %b expected 0", t, got[W]); end
`endif
            end
         end
         checks++; if (lat != 4) begin errors++; $display("FAIL single_latency[%0d]: got %0d expected 4", t, lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic       acc, rdy, ov;
      logic [W:0] got, e;
      int         sent = 0, rcvd = 0, first = -1;
      bit         gap = 1'b0;
      for (int cyc = 0; cyc < 40 && rcvd < 16; cyc++) begin
         cycle(sent < 16, W'(sent) << 15, W'(sent) << 15, 1'b1, acc, rdy, ov, got);
         if (acc) sent++;
         if (ov) begin
            if (first < 0) first = cyc;
            else if (cyc != first + rcvd) gap = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_data: unexpected output %h", got); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", rcvd, got, e); end
            end
            checks++; if (got[W-1:0] !== (W'(rcvd) << 16)) begin errors++; $display("FAIL b2b_prod[%0d]: got %h expected %h", rcvd, got[W-1:0], W'(rcvd) << 16); end
            rcvd++;
         end
      end
      checks++; if (rcvd != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", rcvd); end
      checks++; if (gap) begin errors++; $display("FAIL b2b_gap: got gaps expected none"); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ts [10];
      logic [W-1:0] tc [10];
      logic         acc, rdy, ov, ordy;
      logic [W:0]   got, held, e;
      int           sent = 0, rcvd = 0, cyc = 0;
      for (int i = 0; i < 10; i++) begin
         ts[i] = {$urandom, $urandom};
         tc[i] = {$urandom, $urandom};
      end
      ov = 1'b0;
      got = '0;
      while (!ov && cyc < 20) begin
         cycle(sent < 10, ts[sent % 10], tc[sent % 10], 1'b0, acc, rdy, ov, got);
         if (acc) sent++;
         cyc++;
      end
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_fill: got out_valid %b expected 1 within 20 cycles", ov); end
      held = got;
      for (int k = 0; k < 6; k++) begin
         cycle(sent < 10, ts[sent % 10], tc[sent % 10], 1'b0, acc, rdy, ov, got);
         if (acc) sent++;
         checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, rdy); end
         checks++; if (ov !== 1'b1 || got !== held) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", k, ov, got, held); end
      end
      cyc = 0;
      while (rcvd < 10 && cyc < 100) begin
         ordy = ($urandom_range(0, 3) != 0);
         cycle(sent < 10, ts[sent % 10], tc[sent % 10], ordy, acc, rdy, ov, got);
         if (acc) sent++;
         if (ov && ordy) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL bp_data: unexpected output %h", got); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", rcvd, got, e); end
            end
            rcvd++;
         end
         cyc++;
      end
      checks++; if (rcvd != 10 || sent != 10) begin errors++; $display("FAIL bp_count: got %0d out/%0d in expected 10/10", rcvd, sent); end
   endtask

   task automatic test_reset_midflight();
      logic       acc, rdy, ov;
      logic [W:0] got;
      int         seen = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc, rdy, ov, got);
         checks++; if (acc !== 1'b1) begin errors++; $display("FAIL mid_accept[%0d]: got %b expected 1", i, acc); end
      end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, '0, 1'b1, acc, rdy, ov, got);
         if (ov) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_discard: got %0d outputs expected 0", seen); end
   endtask

   // Two different carry-save splits of 0xFFFFFFFF squared, as the tree could hand over.
   task automatic test_tree_e2e();
      logic [W-1:0] p, r [2];
      logic         acc, rdy, ov;
      logic [W:0]   got, e;
      int           sent = 0, rcvd = 0;
      p    = {32'h0, 32'hFFFF_FFFF} * {32'h0, 32'hFFFF_FFFF};
      r[0] = {$urandom, $urandom};
      r[1] = p & 64'h5555_5555_5555_5555;
      for (int cyc = 0; cyc < 30 && rcvd < 2; cyc++) begin
         cycle(sent < 2, p - r[sent % 2], r[sent % 2], 1'b1, acc, rdy, ov, got);
         if (acc) sent++;
         if (ov) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL tree_data: unexpected output %h", got); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin errors++; $display("FAIL tree_data[%0d]: got %h expected %h", rcvd, got, e); end
            end
            checks++; if (got[W-1:0] !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL tree_prod[%0d]: got %h expected fffffffe00000001", rcvd, got[W-1:0]); end
            rcvd++;
         end
      end
      checks++; if (rcvd != 2) begin errors++; $display("FAIL tree_count: got %0d expected 2", rcvd); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_tree_e2e();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d pending expected 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_cpa_pipe.md
# mul_cpa_pipe

Pipelined carry-propagate adder that resolves the carry-save pair (sum vector, carry vector) from the 32x32 Wallace-tree multiplier into the final 64-bit product. It sits directly downstream of the tree, which ends with one sum and one carry vector. It adds the two vectors in 16-bit slices across a 4-stage staircase pipeline so that the icestick closes timing. It also provides valid/ready flow control toward the consumer.

## Interface
- `WIDTH`, default 64: operand/result width; must be a multiple of `SLICE_W`.
- `SLICE_W`, default 16: bits added per pipeline stage; stage count `NSTG = WIDTH/SLICE_W` (4).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_sum`/`in_carry` hold a carry-save pair.
- `in_ready`  out  1  block accepts the pair this cycle.
- `in_sum`  in  WIDTH  sum vector from the tree.
- `in_carry`  in  WIDTH  carry vector from the tree, already bit-aligned (weight 2^i at bit i).
- `out_valid`  out  1  `out_prod` is valid.
- `out_ready`  in  1  consumer takes `out_prod` this cycle.
- `out_prod`  out  WIDTH  `(in_sum + in_carry) mod 2^WIDTH`.
- `out_cout`  out  1  carry out of bit WIDTH-1 (present only with `MUL_CPA_COUT_EN`).

## Operation
- Transfer on the input occurs when `in_valid && in_ready`. Transfer on the output occurs when `out_valid && out_ready`.
- Global advance enable: `adv = !out_valid || out_ready`. `in_ready = adv` (combinational, no dependency on `in_valid`).
- Stage k (0..NSTG-1) adds slice k of sum and carry plus the carry register from stage k-1. Stage 0 uses carry-in 0.
- Slices above k are carried forward unmodified as raw sum/carry. Slices below k are carried forward as finished result bits.
- Each stage has a valid bit. On `adv`, every stage loads from its predecessor, and stage 0 loads `in_valid`.
- Bubbles propagate: a stage with valid=0 still shifts, and its data is don't-care.
- When `adv`=0 all stage registers and valid bits hold. No data is lost or duplicated.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow beyond bit WIDTH-1 appears only in `out_cout`.

## Timing
- Latency: a pair accepted at edge N appears with `out_valid`=1 after edge N+NSTG (4 cycles), assuming no stall.
- Throughput: one pair per cycle while `out_ready`=1.
- Reset (`rst`=1 at an edge): all stage valid bits 0, `out_valid`=0, `out_prod`=0, `out_cout`=0, carry registers 0.
  - `in_ready`=1 in the cycle after reset, since `out_valid`=0.
- Reset mid-operation discards all in-flight pairs. Nothing is emitted for them.
- `out_valid`=1 with `out_ready`=0: `out_prod`/`out_cout` stay stable until the transfer, and `in_ready`=0.
- Simultaneous output transfer and input transfer in the same cycle is legal. The pipeline shifts by one.
- `in_sum`/`in_carry` are sampled only on an input transfer. Their values at other times are ignored.

## Configuration
- `MUL_CPA_COUT_EN` defined: port `out_cout` exists and carries the final carry of the top slice, registered alongside `out_prod`.
- `MUL_CPA_COUT_EN` undefined: no `out_cout` port. The top-slice carry is discarded and no register is built for it.

## Structure
- Shared package/header `mul_pkg`: `MUL_W=64`, `MUL_CPA_SLICE_W=16`, `MUL_CPA_NSTG=4`. The Wallace tree wrapper and this block both use these.
- One sub-module `cpa_slice`: `SLICE_W`-bit adder, inputs `a`, `b`, `cin`, outputs `s`, `cout`, purely combinational. Instantiated once per stage via generate.
- Pipeline registers, valid chain and handshake logic live in `mul_cpa_pipe` itself.

## Test plan
- Reset then single pair: sum=64'h0000_0000_0000_0003, carry=64'h0000_0000_0000_0005 -> `out_prod`=64'h8 exactly 4 cycles after accept; `out_cout`=0.
- Full carry ripple across all slices: sum=64'hFFFF_FFFF_FFFF_FFFF, carry=64'h1 -> `out_prod`=0, `out_cout`=1 (with macro).
- Back-to-back stream of 16 pairs with the `out_ready`=1 constant: sum=i<<15, carry=i<<15 for i=0..15 -> products i<<16 in order, one per cycle, no gaps after first.
- Backpressure: `out_ready`=0 for 6 cycles while `out_valid`=1 -> `in_ready`=0, `out_prod` stable. Release -> remaining pairs emerge in order, none lost or duplicated.
- Reset mid-flight: accept 3 pairs, assert `rst` one cycle -> `out_valid`=0 next cycle and none of the 3 results ever appear.
- End-to-end with the Wallace tree: A=32'hFFFF_FFFF, B=32'hFFFF_FFFF through the tree into this block -> `out_prod`=64'hFFFF_FFFE_0000_0001.
